// File: rtl/rvfi_mem_pkg.sv
// Shared constants and helpers for the rvfi memory harness channels.
package rvfi_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Dword accesses are only legal on a 64-bit data path.
  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size,
                                      input logic has_dword);
    logic res;
    case (size)
      SZ_B:    res = 1'b0;
      SZ_H:    res = addr_lo[0];
      SZ_W:    res = |addr_lo[1:0];
      default: res = !has_dword || (|addr_lo);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rvfi_mem_chan.sv
// One memory channel: req/gnt handshake, bounded wait states, one-cycle response.
module rvfi_mem_chan
  import rvfi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WAIT  = 4,
  parameter bit          HAS_WRITE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                stall,
  input  logic [DATA_W-1:0]   rand_data,
  output logic                gnt,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                wr_valid,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W/8-1:0] wr_mask,
  output logic [DATA_W-1:0]   wr_data
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned CntW  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [MaskW-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_eff;
  logic [1:0]        size_eff;

  assign we_eff   = HAS_WRITE && we;
  assign size_eff = HAS_WRITE ? size : SZ_W;

  always_comb begin
    // Gated by reset so nothing is granted while the harness is held in reset.
    gnt     = reset && req && (state_q == ST_IDLE || state_q == ST_RESP);
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: begin
        if (stall && cnt_q < CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          state_d = ST_RESP;
          rdata_d = (err_q || we_q) ? '0 : rand_data;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (gnt) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
      addr_d  = addr;
      we_d    = we_eff;
      mask_d  = wmask;
      wdata_d = wdata;
      err_d   = misaligned(addr[2:0], size_eff, DATA_W == 64);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign rvalid   = (state_q == ST_RESP);
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign wr_valid = rvalid && we_q && !err_q;
  assign wr_addr  = addr_q;
  assign wr_mask  = mask_q;
  assign wr_data  = wdata_q;

endmodule

// File: rtl/rvfi_mem_harness.sv
// Two-channel memory model: read-only instruction channel and read/write data channel.
module rvfi_mem_harness
  import rvfi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                i_stall,
  input  logic [DATA_W-1:0]   i_rand_data,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [1:0]          d_size,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  input  logic                d_stall,
  input  logic [DATA_W-1:0]   d_rand_data,
  output logic                wr_valid,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W/8-1:0] wr_mask,
  output logic [DATA_W-1:0]   wr_data
);

  logic                i_wr_valid;
  logic [ADDR_W-1:0]   i_wr_addr;
  logic [DATA_W/8-1:0] i_wr_mask;
  logic [DATA_W-1:0]   i_wr_data;
  logic                unused_i_wr;

  rvfi_mem_chan #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT),
    .HAS_WRITE(1'b0)
  ) u_ichan (
    .clk      (clk),
    .reset    (reset),
    .req      (i_req),
    .addr     (i_addr),
    .we       (1'b0),
    .size     (SZ_W),
    .wmask    ('0),
    .wdata    ('0),
    .stall    (i_stall),
    .rand_data(i_rand_data),
    .gnt      (i_gnt),
    .rvalid   (i_rvalid),
    .rdata    (i_rdata),
    .err      (i_err),
    .wr_valid (i_wr_valid),
    .wr_addr  (i_wr_addr),
    .wr_mask  (i_wr_mask),
    .wr_data  (i_wr_data)
  );

  // The instruction channel never writes, so its trace outputs are dropped.
  assign unused_i_wr = ^{i_wr_valid, i_wr_addr, i_wr_mask, i_wr_data};

  rvfi_mem_chan #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT),
    .HAS_WRITE(1'b1)
  ) u_dchan (
    .clk      (clk),
    .reset    (reset),
    .req      (d_req),
    .addr     (d_addr),
    .we       (d_we),
    .size     (d_size),
    .wmask    (d_wmask),
    .wdata    (d_wdata),
    .stall    (d_stall),
    .rand_data(d_rand_data),
    .gnt      (d_gnt),
    .rvalid   (d_rvalid),
    .rdata    (d_rdata),
    .err      (d_err),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data)
  );

endmodule

// File: tb/tb_rvfi_mem_harness.sv
// Self-checking bench for rvfi_mem_harness against a latency/alignment reference model.
module tb_rvfi_mem_harness;

  localparam int unsigned MW = 4;
  localparam logic [31:0] KMIX = 32'h9E37_79B9;

  logic        clk;
  logic        reset;
  logic        i_req, i_gnt, i_rvalid, i_err, i_stall;
  logic [31:0] i_addr, i_rdata, i_rand_data;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err, d_stall;
  logic [1:0]  d_size;
  logic [3:0]  d_wmask, wr_mask;
  logic [31:0] d_addr, d_wdata, d_rdata, d_rand_data;
  logic        wr_valid;
  logic [31:0] wr_addr, wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  rvfi_mem_harness #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(MW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .i_err      (i_err),
    .i_stall    (i_stall),
    .i_rand_data(i_rand_data),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_wmask    (d_wmask),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .d_stall    (d_stall),
    .d_rand_data(d_rand_data),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_mask    (wr_mask),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: response lands 2 cycles after grant plus leading stall cycles, capped.
  function automatic int model_lat(input logic [7:0] pat);
    int k = 0;
    while (k < int'(MW) && pat[k] == 1'b1) k++;
    return 2 + k;
  endfunction

  function automatic logic model_err(input logic sel, input logic [31:0] addr,
                                     input logic [1:0] size);
    int sz = sel ? int'(size) : 2;
    if (sz == 3) return 1'b1;
    return (addr % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] rand_at(input logic [31:0] base, input int c);
    return base ^ (32'(c) * KMIX);
  endfunction

  function automatic logic [138:0] all_outs();
    return {i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
            wr_valid, wr_addr, wr_mask, wr_data};
  endfunction

  // Issues one access on channel sel (0 = instr, 1 = data) and records what came back.
  task automatic run_access(input logic sel, input logic [31:0] addr, input logic we,
                            input logic [1:0] size, input logic [3:0] mask,
                            input logic [31:0] wdata, input logic [7:0] pat,
                            input logic [31:0] base, output logic gnt0, output int lat,
                            output logic [31:0] rdata, output logic err, output logic wrv,
                            output logic [31:0] wa, output logic [3:0] wm,
                            output logic [31:0] wd, output int extra);
    lat = -1; extra = 0; rdata = '0; err = 1'b0; wrv = 1'b0; wa = '0; wm = '0; wd = '0;
    @(posedge clk); #1;
    if (sel) begin
      d_req = 1'b1; d_addr = addr; d_we = we; d_size = size; d_wmask = mask;
      d_wdata = wdata; d_stall = 1'b0; d_rand_data = base;
    end else begin
      i_req = 1'b1; i_addr = addr; i_stall = 1'b0; i_rand_data = base;
    end
    #1 gnt0 = sel ? d_gnt : i_gnt;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      if (sel) begin
        d_stall = (c <= 8) ? pat[c-1] : 1'b0; d_rand_data = rand_at(base, c);
      end else begin
        i_stall = (c <= 8) ? pat[c-1] : 1'b0; i_rand_data = rand_at(base, c);
      end
      #1;
      if (sel ? d_rvalid : i_rvalid) begin
        if (lat < 0) begin
          lat = c; rdata = sel ? d_rdata : i_rdata; err = sel ? d_err : i_err;
          wrv = wr_valid; wa = wr_addr; wm = wr_mask; wd = wr_data;
        end else begin
          extra++;
        end
      end
    end
    i_stall = 1'b0; d_stall = 1'b0;
  endtask

  task automatic test_reset();
    logic [138:0] obs;
    reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = '0; d_addr = '0; d_we = 1'b0; d_size = 2'd2;
    d_wmask = '0; d_wdata = '0; i_stall = 1'b0; d_stall = 1'b0;
    i_rand_data = '0; d_rand_data = '0;
    #3 obs = all_outs();
    n_tests++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_hold: got %0h expected 0", obs);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    obs = all_outs();
    n_tests++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_idle: got %0h expected 0", obs);
    end
  endtask

  task automatic test_basic_read();
    logic g, e, wv; int lat, ex; logic [31:0] rd, wa, wd; logic [3:0] wm;
    run_access(1'b0, 32'h100, 1'b0, 2'd2, 4'h0, 32'h0, 8'h00, 32'hDEADBEEF ^ KMIX,
               g, lat, rd, e, wv, wa, wm, wd, ex);
    n_tests++;
    if (g !== 1'b1 || lat != 2 || ex != 0) begin
      n_fail++; $display("FAIL iread_timing: got gnt=%0b lat=%0d extra=%0d expected 1 2 0",
                         g, lat, ex);
    end
    n_tests++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      n_fail++; $display("FAIL iread_data: got %h err=%0b expected deadbeef err=0", rd, e);
    end
  endtask

  task automatic test_stall_bound();
    logic g, e, wv; int lat, ex; logic [31:0] rd, wa, wd, base; logic [3:0] wm;
    base = $urandom;
    run_access(1'b1, 32'h8, 1'b0, 2'd2, 4'h0, 32'h0, 8'hFF, base,
               g, lat, rd, e, wv, wa, wm, wd, ex);
    n_tests++;
    if (lat != 2 + int'(MW) || ex != 0 || rd !== rand_at(base, 1 + int'(MW))) begin
      n_fail++; $display("FAIL stall_max: got lat=%0d extra=%0d rdata=%h expected %0d 0 %h",
                         lat, ex, rd, 2 + MW, rand_at(base, 1 + int'(MW)));
    end
    run_access(1'b1, 32'h8, 1'b0, 2'd2, 4'h0, 32'h0, 8'b0000_0011, base,
               g, lat, rd, e, wv, wa, wm, wd, ex);
    n_tests++;
    if (lat != 4 || rd !== rand_at(base, 3)) begin
      n_fail++; $display("FAIL stall_two: got lat=%0d rdata=%h expected 4 %h",
                         lat, rd, rand_at(base, 3));
    end
  endtask

  task automatic test_write();
    logic g, e, wv; int lat, ex; logic [31:0] rd, wa, wd; logic [3:0] wm;
    run_access(1'b1, 32'h20, 1'b1, 2'd2, 4'hF, 32'h12345678, 8'h00, $urandom,
               g, lat, rd, e, wv, wa, wm, wd, ex);
    n_tests++;
    if (lat != 2 || wv !== 1'b1 || rd !== '0 || e !== 1'b0) begin
      n_fail++; $display("FAIL write_resp: got lat=%0d wr_valid=%0b rdata=%h err=%0b expected 2 1 0 0",
                         lat, wv, rd, e);
    end
    n_tests++;
    if (wa !== 32'h20 || wm !== 4'hF || wd !== 32'h12345678) begin
      n_fail++; $display("FAIL write_trace: got %h/%h/%h expected 20/f/12345678", wa, wm, wd);
    end
  endtask

  task automatic test_misaligned();
    logic g, e, wv; int lat, ex; logic [31:0] rd, wa, wd; logic [3:0] wm;
    run_access(1'b1, 32'h3, 1'b0, 2'd1, 4'h0, 32'h0, 8'h00, 32'hFFFF_FFFF,
               g, lat, rd, e, wv, wa, wm, wd, ex);
    n_tests++;
    if (lat != 2 || e !== 1'b1 || rd !== '0) begin
      n_fail++; $display("FAIL mis_half: got lat=%0d err=%0b rdata=%h expected 2 1 0", lat, e, rd);
    end
    run_access(1'b1, 32'h2, 1'b1, 2'd2, 4'hF, 32'hA5A5A5A5, 8'h00, $urandom,
               g, lat, rd, e, wv, wa, wm, wd, ex);
    n_tests++;
    if (lat != 2 || e !== 1'b1 || wv !== 1'b0) begin
      n_fail++; $display("FAIL mis_write: got lat=%0d err=%0b wr_valid=%0b expected 2 1 0",
                         lat, e, wv);
    end
    run_access(1'b1, 32'h0, 1'b0, 2'd3, 4'h0, 32'h0, 8'h00, 32'h1234_0000,
               g, lat, rd, e, wv, wa, wm, wd, ex);
    n_tests++;
    if (lat != 2 || e !== 1'b1 || rd !== '0) begin
      n_fail++; $display("FAIL mis_dword: got lat=%0d err=%0b rdata=%h expected 2 1 0", lat, e, rd);
    end
  endtask

  task automatic test_random();
    logic g, e, wv, sel, we, e_err, e_wr; int lat, ex, e_lat;
    logic [31:0] rd, wa, wd, addr, wdata, base, e_rd; logic [3:0] wm, mask;
    logic [1:0] size; logic [7:0] pat;
    for (int n = 0; n < 24; n++) begin
      sel = 1'($urandom_range(0, 1)); addr = 32'($urandom_range(0, 255));
      we = sel ? 1'($urandom_range(0, 1)) : 1'b0; size = 2'($urandom_range(0, 3));
      mask = 4'($urandom); wdata = $urandom; pat = 8'($urandom); base = $urandom;
      run_access(sel, addr, we, size, mask, wdata, pat, base, g, lat, rd, e, wv, wa, wm, wd, ex);
      e_lat = model_lat(pat);
      e_err = model_err(sel, addr, size);
      e_wr  = we && !e_err;
      e_rd  = (e_err || we) ? 32'h0 : rand_at(base, e_lat - 1);
      n_tests++;
      if (g !== 1'b1 || lat != e_lat || ex != 0) begin
        n_fail++; $display("FAIL rnd%0d_timing: got gnt=%0b lat=%0d extra=%0d expected 1 %0d 0",
                           n, g, lat, ex, e_lat);
      end
      n_tests++;
      if (e !== e_err || rd !== e_rd || wv !== e_wr) begin
        n_fail++; $display("FAIL rnd%0d_resp: got err=%0b rdata=%h wr=%0b expected %0b %h %0b",
                           n, e, rd, wv, e_err, e_rd, e_wr);
      end
      if (e_wr) begin
        n_tests++;
        if (wa !== addr || wm !== mask || wd !== wdata) begin
          n_fail++; $display("FAIL rnd%0d_trace: got %h/%h/%h expected %h/%h/%h",
                             n, wa, wm, wd, addr, mask, wdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ig, dg, iv, dv; logic [31:0] base, e_i; int bad = 0;
    ig = '0; dg = '0; iv = '0; dv = '0;
    base = $urandom;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      i_req = (c <= 4); d_req = (c <= 4);
      i_addr = 32'h200 + 32'(4 * c); d_addr = 32'h300 + 32'(4 * c);
      d_we = 1'b0; d_size = 2'd2; i_stall = 1'b0; d_stall = 1'b0;
      i_rand_data = rand_at(base, c); d_rand_data = ~rand_at(base, c);
      #1;
      ig[c] = i_gnt; dg[c] = d_gnt; iv[c] = i_rvalid; dv[c] = d_rvalid;
      if (c > 0) begin
        e_i = rand_at(base, c - 1);
        if (i_rvalid && i_rdata !== e_i) bad++;
        if (d_rvalid && d_rdata !== ~e_i) bad++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    n_tests++;
    if (ig !== 8'b0001_0101 || dg !== 8'b0001_0101) begin
      n_fail++; $display("FAIL b2b_gnt: got i=%b d=%b expected 00010101", ig, dg);
    end
    n_tests++;
    if (iv !== 8'b0101_0100 || dv !== 8'b0101_0100) begin
      n_fail++; $display("FAIL b2b_rvalid: got i=%b d=%b expected 01010100", iv, dv);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL b2b_data: got %0d bad beats expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [138:0] obs; int seen = 0;
    logic g, e, wv; int lat, ex; logic [31:0] rd, wa, wd; logic [3:0] wm;
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 32'h8; d_we = 1'b0; d_size = 2'd2; d_stall = 1'b1;
    d_rand_data = 32'hCAFE0000;
    @(posedge clk); #1;
    reset = 1'b0;
    #1 obs = all_outs();
    n_tests++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL rst_mid_now: got %0h expected 0", obs);
    end
    repeat (2) @(posedge clk);
    #1 obs = all_outs();
    n_tests++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL rst_mid_hold: got %0h expected 0", obs);
    end
    d_req = 1'b0; d_stall = 1'b0; reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (d_rvalid || i_rvalid || wr_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_mid_norsp: got %0d responses expected 0", seen);
    end
    run_access(1'b1, 32'h40, 1'b0, 2'd2, 4'h0, 32'h0, 8'h00, 32'h0BAD_F00D,
               g, lat, rd, e, wv, wa, wm, wd, ex);
    n_tests++;
    if (g !== 1'b1 || lat != 2 || rd !== rand_at(32'h0BAD_F00D, 1) || e !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got gnt=%0b lat=%0d rdata=%h expected 1 2 %h",
                         g, lat, rd, rand_at(32'h0BAD_F00D, 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_stall_bound();
    test_write();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
